// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot occupancy monitor.
//   lane_state_t : per-lane direction FSM state
//   AB_*         : synchronised {a,b} sensor codes (1 = blocked)
//   clamp_count  : limits a signed next-occupancy value to [0, cap]
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IN1,
        ST_IN2,
        ST_IN3,
        ST_OUT1,
        ST_OUT2,
        ST_OUT3,
        ST_RESYNC
    } lane_state_t;

    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_INNER = 2'b01;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_BOTH  = 2'b11;

    function automatic int clamp_count(input int value, input int cap);
        if (value < 0) begin
            return 0;
        end else if (value > cap) begin
            return cap;
        end
        return value;
    endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One parking lane: sensor synchroniser, direction FSM, registered event pulses.
//   clk, reset : clock, synchronous active-high reset
//   a_in, b_in : raw outer/inner sensors (asynchronous, 1 = blocked)
//   enter      : registered one-cycle pulse on a qualified entry
//   exit       : registered one-cycle pulse on a qualified exit
//   err_c      : combinational, high in the cycle an illegal transition is taken
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    output logic enter,
    output logic exit,
    output logic err_c
);

    logic [1:0]  ab_c;
    lane_state_t state_q, state_d;
    logic        enter_q, enter_d;
    logic        exit_q, exit_d;

    // The lane state register samples the synchronised code and is the last
    // stage of the SYNC_STAGES-deep path, so only SYNC_STAGES-1 plain flops
    // precede it.
    if (SYNC_STAGES > 1) begin : g_sync
        localparam int unsigned DEPTH = SYNC_STAGES - 1;

        logic [DEPTH-1:0] a_sync_q, a_sync_d;
        logic [DEPTH-1:0] b_sync_q, b_sync_d;

        always_comb begin
            a_sync_d    = a_sync_q;
            b_sync_d    = b_sync_q;
            a_sync_d[0] = a_in;
            b_sync_d[0] = b_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                a_sync_d[k] = a_sync_q[k-1];
                b_sync_d[k] = b_sync_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                a_sync_q <= '0;
                b_sync_q <= '0;
            end else begin
                a_sync_q <= a_sync_d;
                b_sync_q <= b_sync_d;
            end
        end

        assign ab_c = {a_sync_q[DEPTH-1], b_sync_q[DEPTH-1]};
    end else begin : g_nosync
        assign ab_c = {a_in, b_in};
    end

    // State register and event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    // Next state: hold on same code, step forward, back up one step, or
    // abort from the first step; anything else is illegal.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        err_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (ab_c)
                    AB_CLEAR: state_d = ST_IDLE;
                    AB_OUTER: state_d = ST_IN1;
                    AB_INNER: state_d = ST_OUT1;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_IN1: begin
                unique case (ab_c)
                    AB_OUTER: state_d = ST_IN1;
                    AB_BOTH:  state_d = ST_IN2;
                    AB_CLEAR: state_d = ST_IDLE;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_IN2: begin
                unique case (ab_c)
                    AB_BOTH:  state_d = ST_IN2;
                    AB_INNER: state_d = ST_IN3;
                    AB_OUTER: state_d = ST_IN1;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_IN3: begin
                unique case (ab_c)
                    AB_INNER: state_d = ST_IN3;
                    AB_CLEAR: begin state_d = ST_IDLE; enter_d = 1'b1; end
                    AB_BOTH:  state_d = ST_IN2;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_OUT1: begin
                unique case (ab_c)
                    AB_INNER: state_d = ST_OUT1;
                    AB_BOTH:  state_d = ST_OUT2;
                    AB_CLEAR: state_d = ST_IDLE;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_OUT2: begin
                unique case (ab_c)
                    AB_BOTH:  state_d = ST_OUT2;
                    AB_OUTER: state_d = ST_OUT3;
                    AB_INNER: state_d = ST_OUT1;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_OUT3: begin
                unique case (ab_c)
                    AB_OUTER: state_d = ST_OUT3;
                    AB_CLEAR: begin state_d = ST_IDLE; exit_d = 1'b1; end
                    AB_BOTH:  state_d = ST_OUT2;
                    default:  begin state_d = ST_RESYNC; err_c = 1'b1; end
                endcase
            end
            ST_RESYNC: begin
                if (ab_c == AB_CLEAR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter = enter_q;
    assign exit  = exit_q;

endmodule

// File: rtl/parking_lot_monitor.sv
// Multi-lane parking-lot occupancy monitor.
//   clk, reset : clock, synchronous active-high reset
//   a, b       : per-lane outer/inner sensors (asynchronous, 1 = blocked)
//   clr_err    : clears all sticky error flags (a same-cycle set wins)
//   enter/exit : per-lane one-cycle qualified passage pulses
//   count      : saturating occupancy in [0, CAPACITY]
//   full/empty : decoded from the count register
//   lane_err   : sticky per-lane illegal-sequence flag
//   ovf_err    : sticky, an increment was clamped at CAPACITY
//   unf_err    : sticky, a decrement was clamped at 0
module parking_lot_monitor
    import parking_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned CAPACITY    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic             clr_err,
    output logic [LANES-1:0] enter,
    output logic [LANES-1:0] exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [LANES-1:0] lane_err,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int unsigned SUM_W = CNT_W + 4;

    logic [LANES-1:0]        lane_err_c;
    logic [LANES-1:0]        lane_err_q, lane_err_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [SUM_W-1:0] net_c;
    logic signed [SUM_W-1:0] sum_c;
    logic                    ovf_c;
    logic                    unf_c;

    for (genvar gi = 0; gi < int'(LANES); gi++) begin : g_lane
        parking_lane_fsm #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .a_in  (a[gi]),
            .b_in  (b[gi]),
            .enter (enter[gi]),
            .exit  (exit[gi]),
            .err_c (lane_err_c[gi])
        );
    end

    // Whole-cycle net across lanes, then clamp once
    always_comb begin
        net_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            net_c = net_c + $signed(SUM_W'(enter[i])) - $signed(SUM_W'(exit[i]));
        end
        sum_c   = $signed(SUM_W'(count_q)) + net_c;
        ovf_c   = sum_c > $signed(SUM_W'(CAPACITY));
        unf_c   = sum_c < $signed(SUM_W'(0));
        count_d = CNT_W'(clamp_count(int'(sum_c), int'(CAPACITY)));
    end

    // Sticky flags: set has priority over clear
    always_comb begin
        lane_err_d = (lane_err_q & ~{LANES{clr_err}}) | lane_err_c;
        ovf_d      = (ovf_q & ~clr_err) | ovf_c;
        unf_d      = (unf_q & ~clr_err) | unf_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            lane_err_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            lane_err_q <= lane_err_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign count    = count_q;
    assign full     = count_q == CNT_W'(CAPACITY);
    assign empty    = count_q == '0;
    assign lane_err = lane_err_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;

endmodule

// File: tb/tb_parking_lot_monitor.sv
// Directed self-checking bench for parking_lot_monitor.
// dut   : default parameters (2 lanes, capacity 16, 2 sync stages)
// dut_s : capacity 2, used for saturation checks
module tb_parking_lot_monitor;

    logic       clk;
    logic       reset;
    logic       clr_err;
    logic       sel_s;
    logic [1:0] a_t, b_t;
    logic [1:0] a_m, b_m, a_s, b_s;

    logic [1:0] enter, exit, lane_err;
    logic [4:0] count;
    logic       full, empty, ovf_err, unf_err;

    logic [1:0] enter_s, exit_s, lane_err_s;
    logic [1:0] count_s;
    logic       full_s, empty_s, ovf_s, unf_s;

    int compared = 0;
    int failed   = 0;
    int ent0_cnt = 0;
    int ext1_cnt = 0;

    assign a_m = sel_s ? 2'b00 : a_t;
    assign b_m = sel_s ? 2'b00 : b_t;
    assign a_s = sel_s ? a_t : 2'b00;
    assign b_s = sel_s ? b_t : 2'b00;

    parking_lot_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a_m),
        .b        (b_m),
        .clr_err  (clr_err),
        .enter    (enter),
        .exit     (exit),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .lane_err (lane_err),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    parking_lot_monitor #(.CAPACITY(2)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .a        (a_s),
        .b        (b_s),
        .clr_err  (clr_err),
        .enter    (enter_s),
        .exit     (exit_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s),
        .lane_err (lane_err_s),
        .ovf_err  (ovf_s),
        .unf_err  (unf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the main DUT, sampled away from the active edge
    always @(negedge clk) begin
        if (enter[0]) ent0_cnt++;
        if (exit[1])  ext1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one {a,b} code per lane for one cycle
    task automatic drive(input logic [1:0] c0, input logic [1:0] c1);
        a_t = {c1[1], c0[1]};
        b_t = {c1[0], c0[0]};
        tick();
    endtask

    task automatic entry0();
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b00);
        tick();
        tick();
    endtask

    task automatic exit1();
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b10);
        drive(2'b00, 2'b00);
        tick();
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        clr_err = 1'b0;
        sel_s   = 1'b0;
        a_t     = 2'b00;
        b_t     = 2'b00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_enter", 32'(enter), 0);
        chk("rst_exit", 32'(exit), 0);
        chk("rst_lane_err", 32'(lane_err), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_unf", 32'(unf_err), 0);

        // Single entry on lane 0 with latency check
        drive(2'b00, 2'b00);
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b00);
        chk("entry_not_yet", 32'(enter), 0);
        tick();
        chk("entry_pulse", 32'(enter), 1);
        chk("entry_count_before", 32'(count), 0);
        tick();
        chk("entry_pulse_gone", 32'(enter), 0);
        chk("entry_count", 32'(count), 1);
        chk("entry_empty", 32'(empty), 0);

        // Abort on lane 1, then exit with back-ups
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b00);
        tick();
        tick();
        chk("abort_no_exit", 32'(ext1_cnt), 0);
        chk("abort_no_err", 32'(lane_err), 0);
        chk("abort_count", 32'(count), 1);
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b10);
        drive(2'b00, 2'b00);
        tick();
        chk("exit_pulse", 32'(exit), 2);
        tick();
        chk("exit_count", 32'(count), 0);
        chk("exit_empty", 32'(empty), 1);
        chk("exit_once", 32'(ext1_cnt), 1);

        // Simultaneous entry and exit at count 5
        for (int n = 0; n < 5; n++) entry0();
        chk("five_count", 32'(count), 5);
        drive(2'b10, 2'b01);
        drive(2'b11, 2'b11);
        drive(2'b01, 2'b10);
        drive(2'b00, 2'b00);
        tick();
        chk("sim_enter", 32'(enter), 1);
        chk("sim_exit", 32'(exit), 2);
        tick();
        chk("sim_count", 32'(count), 5);
        chk("sim_ovf", 32'(ovf_err), 0);
        chk("sim_unf", 32'(unf_err), 0);

        // Illegal sequence: IDLE on 11
        drive(2'b11, 2'b00);
        chk("illegal_not_yet", 32'(lane_err), 0);
        tick();
        chk("illegal_err", 32'(lane_err), 1);
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        drive(2'b01, 2'b00);
        tick();
        tick();
        chk("resync_no_enter", 32'(ent0_cnt), 7);
        chk("resync_count", 32'(count), 5);
        drive(2'b00, 2'b00);
        entry0();
        chk("after_resync_count", 32'(count), 6);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_lane_err", 32'(lane_err), 0);
        chk("clr_keeps_count", 32'(count), 6);

        // Reset while lane 0 is in IN2, release with 11 held
        drive(2'b10, 2'b00);
        drive(2'b11, 2'b00);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_enter", 32'(enter), 0);
        chk("midrst_lane_err", 32'(lane_err), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("midrst_held_err", 32'(lane_err), 1);
        drive(2'b00, 2'b00);
        tick();

        // Saturation on the capacity-2 instance
        sel_s = 1'b1;
        entry0();
        entry0();
        chk("sat_count2", 32'(count_s), 2);
        chk("sat_full", 32'(full_s), 1);
        chk("sat_no_ovf", 32'(ovf_s), 0);
        entry0();
        chk("sat_count_hold", 32'(count_s), 2);
        chk("sat_ovf", 32'(ovf_s), 1);
        exit1();
        exit1();
        chk("sat_count0", 32'(count_s), 0);
        chk("sat_no_unf", 32'(unf_s), 0);
        exit1();
        chk("sat_count_floor", 32'(count_s), 0);
        chk("sat_unf", 32'(unf_s), 1);
        chk("sat_ovf_sticky", 32'(ovf_s), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("sat_clr_ovf", 32'(ovf_s), 0);
        chk("sat_clr_unf", 32'(unf_s), 0);
        chk("sat_clr_count", 32'(count_s), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
